// File: rtl/sprite_ctrl_pkg.sv
// Shared types and constants for the sprite controller.
// FSM state encoding, register selectors and write-pipe drain depth.
package sprite_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] REG_SEL_X     = 2'd0;
  localparam logic [1:0] REG_SEL_Y     = 2'd1;
  localparam logic [1:0] REG_SEL_SCALE = 2'd2;

  localparam int DRAIN_DEPTH = 2;

endpackage

// File: rtl/sprite_ctrl_regs.sv
// Sprite position/scale registers (x, y, scale).
// Ports: clk, reset (async, high), reg_we/reg_sel/reg_wdata write port,
// frame_start commit pulse, x/y/scale outputs.
// Macro SPRITE_CTRL_FRAME_COMMIT_EN: writes land in shadows and are
// committed together on frame_start; otherwise writes go straight out.
module sprite_ctrl_regs
  import sprite_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] reg_wdata,
  input  logic        frame_start,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] scale
);

  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] scale_q, scale_d;

`ifdef SPRITE_CTRL_FRAME_COMMIT_EN
  logic [31:0] sx_q, sx_d;
  logic [31:0] sy_q, sy_d;
  logic [31:0] ss_q, ss_d;

  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    ss_d    = ss_q;
    x_d     = x_q;
    y_d     = y_q;
    scale_d = scale_q;
    // Commit reads the pre-write shadow, so a same-cycle write
    // waits for the following frame.
    if (frame_start) begin
      x_d     = sx_q;
      y_d     = sy_q;
      scale_d = ss_q;
    end
    if (reg_we) begin
      case (reg_sel)
        REG_SEL_X:     sx_d = reg_wdata;
        REG_SEL_Y:     sy_d = reg_wdata;
        REG_SEL_SCALE: ss_d = reg_wdata;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx_q <= '0;
      sy_q <= '0;
      ss_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      ss_q <= ss_d;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    scale_d = scale_q;
    if (reg_we) begin
      case (reg_sel)
        REG_SEL_X:     x_d     = reg_wdata;
        REG_SEL_Y:     y_d     = reg_wdata;
        REG_SEL_SCALE: scale_d = reg_wdata;
        default:       ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      scale_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      scale_q <= scale_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign scale = scale_q;

endmodule

// File: rtl/sprite_ctrl.sv
// Sprite controller: copies bytes from source memory into the sprite
// bitmap RAM (one per cycle) and holds the x/y/scale registers.
// Ports: cmd_* handshake, src_* read port, bitmap_* write port,
// busy/done/err status, reg_* write port, frame_start, x/y/scale.
// Macro SPRITE_CTRL_FRAME_COMMIT_EN selects frame-committed registers.
module sprite_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int SRC_ADDR_BITS = 16,
  parameter int DST_ADDR_BITS = 12,
  parameter int BPP           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SRC_ADDR_BITS-1:0] cmd_src,
  input  logic [DST_ADDR_BITS-1:0] cmd_dst,
  input  logic [DST_ADDR_BITS:0]   cmd_len,
  output logic [SRC_ADDR_BITS-1:0] src_addr,
  output logic                     src_oe,
  input  logic [BPP-1:0]           src_din,
  input  logic [31:0]              bitmap_length,
  output logic [31:0]              bitmap_address,
  output logic [BPP-1:0]           bitmap_din,
  output logic                     bitmap_we,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     reg_we,
  input  logic [1:0]               reg_sel,
  input  logic [31:0]              reg_wdata,
  input  logic                     frame_start,
  output logic [31:0]              x,
  output logic [31:0]              y,
  output logic [31:0]              scale
);

  state_t                   state_q, state_d;
  logic [SRC_ADDR_BITS-1:0] src_addr_q, src_addr_d;
  logic [DST_ADDR_BITS:0]   rem_q, rem_d;
  logic [1:0]               drain_q, drain_d;
  logic [DST_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic                     rd_v_q, rd_v_d;
  logic                     we_q, we_d;
  logic [BPP-1:0]           din_q, din_d;
  logic [DST_ADDR_BITS-1:0] baddr_q, baddr_d;
  logic                     oe_q, oe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     rdy_q, rdy_d;

  // Two extra bits so dst + len can never wrap.
  logic [DST_ADDR_BITS+1:0] end_sum;
  logic                     over;

  assign end_sum = {2'b00, cmd_dst} + {1'b0, cmd_len};
  assign over    = 32'(end_sum) > bitmap_length;

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    wr_addr_d  = wr_addr_q;
    din_d      = din_q;
    baddr_d    = baddr_q;
    err_d      = 1'b0;
    // Read issued now returns next cycle, then is written a cycle later.
    rd_v_d     = oe_q;
    we_d       = rd_v_q;
    if (rd_v_q) begin
      din_d     = src_din;
      baddr_d   = wr_addr_q;
      wr_addr_d = wr_addr_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_addr_d = cmd_src;
          wr_addr_d  = cmd_dst;
          rem_d      = cmd_len;
          if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else if (over) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        src_addr_d = src_addr_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        if (rem_q == (DST_ADDR_BITS+1)'(1)) begin
          state_d = ST_DRAIN;
          drain_d = 2'(DRAIN_DEPTH - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) state_d = ST_FIN;
        else                 drain_d = drain_q - 2'd1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    oe_d   = state_d == ST_READ;
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_FIN;
    rdy_d  = state_d == ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_addr_q <= '0;
      rem_q      <= '0;
      drain_q    <= '0;
      wr_addr_q  <= '0;
      rd_v_q     <= 1'b0;
      we_q       <= 1'b0;
      din_q      <= '0;
      baddr_q    <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      wr_addr_q  <= wr_addr_d;
      rd_v_q     <= rd_v_d;
      we_q       <= we_d;
      din_q      <= din_d;
      baddr_q    <= baddr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  assign cmd_ready      = rdy_q;
  assign src_addr       = src_addr_q;
  assign src_oe         = oe_q;
  assign bitmap_address = 32'(baddr_q);
  assign bitmap_din     = din_q;
  assign bitmap_we      = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

  sprite_ctrl_regs u_regs (
    .clk         (clk),
    .reset       (reset),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .reg_wdata   (reg_wdata),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .scale       (scale)
  );

endmodule

// File: tb/tb_sprite_ctrl.sv
// Directed bench for sprite_ctrl; source memory returns addr[7:0]+0xA0.
// Register checks follow SPRITE_CTRL_FRAME_COMMIT_EN when defined.
module tb_sprite_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_src = '0;
  logic [11:0] cmd_dst = '0;
  logic [12:0] cmd_len = '0;
  logic [15:0] src_addr;
  logic        src_oe;
  logic [7:0]  src_din = '0;
  logic [31:0] bitmap_length = 32'd4096;
  logic [31:0] bitmap_address;
  logic [7:0]  bitmap_din;
  logic        bitmap_we;
  logic        busy, done, err;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_sel = '0;
  logic [31:0] reg_wdata = '0;
  logic        frame_start = 1'b0;
  logic [31:0] x, y, scale;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (src_oe) src_din <= src_addr[7:0] + 8'hA0;

  sprite_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .src_addr(src_addr), .src_oe(src_oe), .src_din(src_din),
    .bitmap_length(bitmap_length), .bitmap_address(bitmap_address),
    .bitmap_din(bitmap_din), .bitmap_we(bitmap_we),
    .busy(busy), .done(done), .err(err),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .frame_start(frame_start),
    .x(x), .y(y), .scale(scale)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drives a command in cycle T; returns in cycle T+1.
  task automatic send(input logic [15:0] s, input logic [11:0] d,
                      input logic [12:0] n);
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = n;
    cmd_valid = 1'b1;
    chk("cmd_ready_at_T", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wreg(input logic [1:0] s, input logic [31:0] v);
    reg_we    = 1'b1;
    reg_sel   = s;
    reg_wdata = v;
  endtask

  initial begin
    int wc;
    logic [31:0] la;
    logic [7:0]  ld;
    int seen;

    repeat (2) step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", bitmap_we, 0);
    chk("rst_x", x, 0);
    reset = 1'b0;
    repeat (2) step();

    // Basic copy: 4 bytes from 0x100 to address 0.
    send(16'h0100, 12'd0, 13'd4);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t1_oe_c%0d", c), src_oe, (c <= 4) ? 1 : 0);
      if (c <= 4)
        chk($sformatf("t1_sa_c%0d", c), src_addr, 32'h100 + c - 1);
      chk($sformatf("t1_we_c%0d", c), bitmap_we,
          (c >= 3 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("t1_ad_c%0d", c), bitmap_address, c - 3);
        chk($sformatf("t1_dt_c%0d", c), bitmap_din, 32'hA0 + c - 3);
      end
      chk($sformatf("t1_done_c%0d", c), done, (c == 7) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", c), busy, 1);
      if (c == 7) chk("t1_err", err, 0);
      step();
    end
    chk("t1_idle_ready", cmd_ready, 1);
    chk("t1_idle_busy", busy, 0);

    // Out-of-range: 4090 + 8 > 4096.
    send(16'h0000, 12'd4090, 13'd8);
    chk("t2_done", done, 1);
    chk("t2_err", err, 1);
    chk("t2_busy", busy, 1);
    chk("t2_oe", src_oe, 0);
    chk("t2_we", bitmap_we, 0);
    step();
    chk("t2_done_off", done, 0);
    chk("t2_ready", cmd_ready, 1);
    chk("t2_we2", bitmap_we, 0);

    // Zero length.
    send(16'h0000, 12'd0, 13'd0);
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);
    chk("t3_oe", src_oe, 0);
    step();

    // Exact fit 4088 + 8 = 4096, source wraps past 0xFFFF.
    send(16'hFFFC, 12'd4088, 13'd8);
    for (int c = 1; c <= 11; c++) begin
      if (c == 1) chk("t4_oe", src_oe, 1);
      if (c == 10) begin
        chk("t4_we_last", bitmap_we, 1);
        chk("t4_ad_last", bitmap_address, 4095);
        chk("t4_dt_last", bitmap_din, 8'hA3);
      end
      if (c == 11) begin
        chk("t4_done", done, 1);
        chk("t4_err", err, 0);
      end
      step();
    end

    // Full 4096-byte copy.
    send(16'h0000, 12'd0, 13'd4096);
    wc = 0;
    la = '0;
    ld = '0;
    for (int c = 1; c <= 4098; c++) begin
      if (bitmap_we) begin
        wc++;
        la = bitmap_address;
        ld = bitmap_din;
      end
      step();
    end
    chk("t5_count", wc, 4096);
    chk("t5_last_ad", la, 4095);
    chk("t5_last_dt", ld, 8'h9F);
    chk("t5_done", done, 1);
    chk("t5_err", err, 0);
    step();

`ifdef SPRITE_CTRL_FRAME_COMMIT_EN
    wreg(2'd0, 32'd40);
    step();
    wreg(2'd1, 32'd20);
    step();
    reg_we = 1'b0;
    chk("r_x_held", x, 0);
    chk("r_y_held", y, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("r_x_commit", x, 40);
    chk("r_y_commit", y, 20);
    wreg(2'd0, 32'd99);
    frame_start = 1'b1;
    step();
    reg_we = 1'b0;
    frame_start = 1'b0;
    chk("r_x_old", x, 40);
    step();
    chk("r_x_still", x, 40);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("r_x_99", x, 99);
    chk("r_y_keep", y, 20);
`else
    wreg(2'd2, 32'd3);
    step();
    reg_we = 1'b0;
    chk("r_scale", scale, 3);
    wreg(2'd0, 32'd40);
    step();
    wreg(2'd1, 32'd20);
    chk("r_x", x, 40);
    step();
    reg_we = 1'b0;
    chk("r_y", y, 20);
    wreg(2'd3, 32'd77);
    step();
    reg_we = 1'b0;
    chk("r_sel3_x", x, 40);
    chk("r_sel3_y", y, 20);
    chk("r_sel3_s", scale, 3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("r_fs_x", x, 40);
    chk("r_fs_s", scale, 3);
`endif

    // Reset in the middle of a 16-byte copy.
    send(16'h0200, 12'd0, 13'd16);
    repeat (4) step();
    chk("t6_we_pre", bitmap_we, 1);
    chk("t6_ad_pre", bitmap_address, 2);
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_oe", src_oe, 0);
    chk("t6_we", bitmap_we, 0);
    chk("t6_ad", bitmap_address, 0);
    chk("t6_dt", bitmap_din, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    chk("t6_x", x, 0);
    chk("t6_y", y, 0);
    chk("t6_ready", cmd_ready, 1);
    step();
    step();
    reset = 1'b0;
    step();
    chk("t6_ready_rel", cmd_ready, 1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || bitmap_we || src_oe) seen++;
      step();
    end
    chk("t6_no_done", seen, 0);
`ifdef SPRITE_CTRL_FRAME_COMMIT_EN
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("t6_shadow_clr", x, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_ctrl.md
# sprite_ctrl

Sprite controller in the `clk` domain, in front of the `sprite` block. It copies bitmap bytes from a CPU-side source memory into the sprite bitmap RAM at one byte per cycle, with a command handshake. It also holds the sprite position and scale registers (`x`, `y`, `scale`) that feed the sprite's CDC synchronizers. With the configuration macro defined, those registers are double-buffered and change only at frame start.

## Interface
- `SRC_ADDR_BITS`, 16, source memory address width
- `DST_ADDR_BITS`, 12, bitmap address width (64×64 sprite)
- `BPP`, 8, bits per pixel
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  copy request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_src`  in  SRC_ADDR_BITS  first source address
- `cmd_dst`  in  DST_ADDR_BITS  first bitmap address
- `cmd_len`  in  DST_ADDR_BITS+1  byte count, 0..4096
- `src_addr`  out  SRC_ADDR_BITS  source read address
- `src_oe`  out  1  source read strobe; data returns on `src_din` one cycle later
- `src_din`  in  BPP  source read data
- `bitmap_length`  in  32  bitmap size reported by `sprite`
- `bitmap_address`  out  32  to `sprite`; upper bits zero
- `bitmap_din`  out  BPP  to `sprite`
- `bitmap_we`  out  1  to `sprite`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse at the end of every accepted command
- `err`  out  1  valid with `done`; command was rejected
- `reg_we`  in  1  register write strobe
- `reg_sel`  in  2  0 = x, 1 = y, 2 = scale, 3 = ignored
- `reg_wdata`  in  32  register write data
- `frame_start`  in  1  one-cycle pulse, already synchronized into the `clk` domain
- `x`, `y`, `scale`  out  32 each  to `sprite`

## Operation
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_src`, `cmd_dst` and `cmd_len`.
  - If `cmd_len`=0, go to FIN with `err`=0.
  - If `cmd_dst`+`cmd_len` > `bitmap_length`, go to FIN with `err`=1. Compute the sum at DST_ADDR_BITS+2 width so it cannot overflow. No writes occur.
  - Otherwise go to READ.
- READ: `src_oe`=1 each cycle. `src_addr` increments by 1 per cycle and wraps modulo 2^SRC_ADDR_BITS. A remaining-count register decrements each cycle. After the N-th read, go to DRAIN.
- Write path: `src_din` is registered into `bitmap_din`, with `bitmap_we` driven from a 2-stage valid pipe. The destination address increments on each write and never wraps, because of the range check.
- DRAIN: hold for 2 cycles until the last write retires, then go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `busy` = state ≠ IDLE. `cmd_valid` is ignored while busy.
- Register writes: `reg_we` with `reg_sel` writes the selected register; `reg_sel`=3 is a no-op. Writes are accepted in every FSM state, independent of copies.
- Reset (including mid-transfer): the transfer is abandoned with no `done`. All outputs go to 0: `busy`, `done`, `err`, `src_oe`, `bitmap_we`, `bitmap_address`, `bitmap_din`, `x`, `y`, `scale`, and any shadow registers. `cmd_ready` goes to 1.

## Timing
- Command accepted at cycle T, with length N ≥ 1:
  - `src_oe` high at T+1..T+N
  - `bitmap_we` high at T+3..T+N+2; write k carries `cmd_dst`+k and the source byte at `cmd_src`+k
  - `done` at T+N+3
  - `busy` high at T+1..T+N+3
- Rejected or zero-length command: `done` at T+1, with `busy` high at T+1.
- Back-to-back commands: next acceptance at the earliest T+N+4.
- Register direct path: the output updates on the cycle after `reg_we`.
- All outputs are registered.

## Configuration
- `SPRITE_CTRL_FRAME_COMMIT_EN` defined:
  - `reg_we` writes shadow registers only.
  - `frame_start` copies all three shadows to `x`/`y`/`scale` in one cycle, so the outputs change atomically.
  - `reg_we` in the same cycle as `frame_start`: the commit takes the old shadow value; the new value stays in the shadow until the next frame.
- Not defined: there are no shadow registers, writes go straight to the outputs, and `frame_start` is ignored.

## Structure
- Package `sprite_ctrl_pkg`: FSM state enum, `REG_SEL_X`/`REG_SEL_Y`/`REG_SEL_SCALE` constants, and the DRAIN depth constant (2).
- One sub-module, `sprite_ctrl_regs`: the x/y/scale registers and shadow logic. It is the only place the macro is tested.

## Test plan
- cmd_src=0x100, dst=0, len=4, source memory holds 0xA0..0xA3 → `bitmap_we` at T+3..T+6 writing addresses 0..3 with data 0xA0..0xA3; `done`=1, `err`=0 at T+7.
- dst=4090, len=8, `bitmap_length`=4096 → no `src_oe`, no `bitmap_we`; `done`=1, `err`=1 at T+1.
- len=0 → `done` at T+1 with `err`=0; len=4096, dst=0 → 4096 writes, last to address 4095.
- Reset asserted at T+5 of a len=16 copy → all outputs 0 immediately; `cmd_ready`=1 after release; no `done`.
- With the macro: write x=40, y=20 → `x`/`y` unchanged until `frame_start`, then both update in the same cycle. `reg_we` x=99 in the same cycle as `frame_start` → x outputs the old shadow; 99 appears at the next `frame_start`.
- Without the macro: `reg_we` scale=3 → `scale`=3 on the next cycle; `frame_start` has no effect.
